ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (64 x 8 by default) between requesters A and B.
- Issues at most one RAM access (read or write) per clock.
- Routes the registered read data back to the requester that issued the read, with a valid strobe.
- Sits between client logic and the RAM instance, and drives all RAM ports directly.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 6, RAM address width (depth = 2**ADDR_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a_req  input  1  requester A access request.
- a_we  input  1  A: 1 = write, 0 = read.
- a_addr  input  ADDR_W  A address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  A granted this cycle (combinational).
- a_rvalid  output  1  A read data valid (registered).
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_data  output  DATA_W  RAM write data.
- ram_q  input  DATA_W  RAM read data. Reflects the address sampled at the previous rising edge (1-cycle read latency).

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. Single clock domain.
- State:
  - last_gnt: 1 bit, 0 = A last granted, 1 = B last granted.
  - rd_pend_a, rd_pend_b: 1 bit each.
- Reset values:
  - last_gnt = 1, so A wins the first tie.
  - rd_pend_a = rd_pend_b = 0.
  - a_rvalid = b_rvalid = 0.
- While rst = 1:
  - a_gnt = b_gnt = 0.
  - ram_we = 0, ram_addr = 0, ram_data = 0.
- Arbitration (combinational, only when rst = 0):
  - Only a_req: a_gnt = 1.
  - Only b_req: b_gnt = 1.
  - Both: grant the requester that was not last granted (round-robin).
  - Neither: no grant.
  - a_gnt and b_gnt are never both 1.
- Transfer:
  - Occurs at the rising edge where gnt = 1.
  - The requester holds req/we/addr/wdata stable until it samples gnt = 1.
  - It may keep req high for back-to-back accesses; one access per grant.
- RAM drive in a granted cycle:
  - ram_addr = winner addr; ram_data = winner wdata; ram_we = winner we.
- RAM drive in a non-granted cycle:
  - ram_we = 0, ram_addr = 0, ram_data = 0.
- last_gnt updates to the winner on every grant edge; unchanged otherwise.
- Read return:
  - A read granted to X at edge k sets rd_pend_X = 1 at edge k.
  - X_rvalid = rd_pend_X during cycle k..k+1, i.e. asserted for exactly the 1 cycle following the grant.
  - X_rdata = ram_q while X_rvalid = 1; 0 otherwise.
- Writes produce no rvalid.
- Back-to-back reads, alternating or from the same requester, yield rvalid every cycle with no bubbles.
- Write then read of the same address on consecutive grants: the read returns the newly written data.
- Single requester continuously requesting: granted every cycle. The other requester is never starved; maximum wait is 1 cycle once both request.
- Reset mid-operation:
  - Pending rvalid is dropped and does not appear after reset.
  - last_gnt returns to 1.
  - An in-flight grant in the same cycle as rst is suppressed, so no RAM write occurs.
- Latency:
  - Grant is 0 cycles after req (when uncontended).
  - Read data is 1 cycle after the grant edge.

Test Plan:
- Reset, then A writes 8'hAA @5, next cycle A reads @5 -> a_gnt = 1 both cycles; cycle after the read grant: a_rvalid = 1, a_rdata = 8'hAA; b_rvalid stays 0.
- A and B both request every cycle for 4 cycles, starting after reset -> grants A, B, A, B; ram_addr alternates between a_addr and b_addr.
- B writes 8'h55 @25, then A reads @25 on the following grant -> a_rdata = 8'h55 with a_rvalid for exactly 1 cycle.
- A reads @5 while B reads @55 (which holds 8'h45), contended -> a_rvalid then b_rvalid on consecutive cycles, returning 8'hAA and 8'h45, never both high.
- A write request to @55 with wdata 8'h00 is presented while rst = 1, then a read @55 -> read returns the prior value 8'h45 (no write during reset); a read granted the cycle before rst gives no rvalid after reset.
- Only B requests for 3 cycles, then A joins -> B granted 3 times; A granted on the next cycle (last_gnt = B).

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester A/B handshakes and the single-port RAM drive/return lines.
interface ram_port_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) ();
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;

   // Environment side: clients plus the RAM instance
   modport master (
      output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
      input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             ram_we, ram_addr, ram_data
   );

   // Arbiter side
   modport slave (
      input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_q,
      output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
             ram_we, ram_addr, ram_data
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B,
// steering the one-cycle-latency read data back to whichever side issued the read.
module ram_port_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input logic                clk,
   input logic                rst,
   ram_port_arbiter_if.slave  bus
);

   logic last_gnt;
   logic rd_pend_a;
   logic rd_pend_b;
   logic gnt_a;
   logic gnt_b;

   // Grant: a lone requester always wins; on a tie the side not granted last wins
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         if (bus.a_req && (!bus.b_req || last_gnt))
            gnt_a = 1'b1;
         else if (bus.b_req)
            gnt_b = 1'b1;
      end
   end

   // RAM drive follows the winner; idle cycles park the bus at zero
   always_comb begin
      bus.ram_we   = 1'b0;
      bus.ram_addr = ADDR_W'(0);
      bus.ram_data = DATA_W'(0);
      if (gnt_a) begin
         bus.ram_we   = bus.a_we;
         bus.ram_addr = bus.a_addr;
         bus.ram_data = bus.a_wdata;
      end else if (gnt_b) begin
         bus.ram_we   = bus.b_we;
         bus.ram_addr = bus.b_addr;
         bus.ram_data = bus.b_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt  <= 1'b1;
         rd_pend_a <= 1'b0;
         rd_pend_b <= 1'b0;
      end else begin
         if (gnt_a)
            last_gnt <= 1'b0;
         else if (gnt_b)
            last_gnt <= 1'b1;
         rd_pend_a <= gnt_a && !bus.a_we;
         rd_pend_b <= gnt_b && !bus.b_we;
      end
   end

   // ram_q already reflects the address granted one edge earlier
   always_comb begin
      bus.a_gnt    = gnt_a;
      bus.b_gnt    = gnt_b;
      bus.a_rvalid = rd_pend_a;
      bus.b_rvalid = rd_pend_b;
      bus.a_rdata  = rd_pend_a ? bus.ram_q : DATA_W'(0);
      bus.b_rdata  = rd_pend_b ? bus.ram_q : DATA_W'(0);
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x8 single-port RAM behind it.
module tb_ram_port_arbiter;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 6;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
      bus.ram_q <= mem[bus.ram_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_a(1'b1, 1'b1, 6'd7, 8'h11);
      set_b(1'b1, 1'b1, 6'd9, 8'h22);
      tick();
      tick();
      #1;
      checks++; if (bus.a_gnt !== 1'b0) begin errors++; $display("FAIL rst_a_gnt: got %b want 0", bus.a_gnt); end
      checks++; if (bus.b_gnt !== 1'b0) begin errors++; $display("FAIL rst_b_gnt: got %b want 0", bus.b_gnt); end
      checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b want 0", bus.ram_we); end
      checks++; if (bus.ram_addr !== 6'd0) begin errors++; $display("FAIL rst_ram_addr: got %0d want 0", bus.ram_addr); end
      checks++; if (bus.ram_data !== 8'h00) begin errors++; $display("FAIL rst_ram_data: got %h want 00", bus.ram_data); end
      checks++; if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {bus.a_rvalid, bus.b_rvalid}); end
      do_reset();
   endtask

   task automatic test_write_read();
      set_a(1'b1, 1'b1, 6'd5, 8'hAA);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
      checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_data} !== {1'b1, 6'd5, 8'hAA}) begin errors++; $display("FAIL wr_ram: got we=%b addr=%0d data=%h want we=1 addr=5 data=aa", bus.ram_we, bus.ram_addr, bus.ram_data); end
      tick();
      set_a(1'b1, 1'b0, 6'd5, 8'h00);
      #1;
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", bus.a_gnt); end
      checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", bus.a_rvalid); end
      checks++; if ({bus.ram_we, bus.ram_addr} !== {1'b0, 6'd5}) begin errors++; $display("FAIL rd_ram: got we=%b addr=%0d want we=0 addr=5", bus.ram_we, bus.ram_addr); end
      tick();
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      checks++; if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL wr_rd_data: got v=%b d=%h want v=1 d=aa", bus.a_rvalid, bus.a_rdata); end
      checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rd_b_rvalid: got %b want 0", bus.b_rvalid); end
      checks++; if ({bus.ram_we, bus.ram_addr, bus.ram_data} !== 15'd0) begin errors++; $display("FAIL idle_ram: got we=%b addr=%0d data=%h want all 0", bus.ram_we, bus.ram_addr, bus.ram_data); end
      tick();
      #1;
      checks++; if ({bus.a_rvalid, bus.a_rdata} !== {1'b0, 8'h00}) begin errors++; $display("FAIL wr_rd_one_cycle: got v=%b d=%h want v=0 d=00", bus.a_rvalid, bus.a_rdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_gnt [4];
      logic [5:0] exp_addr [4];
      exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
      exp_addr[0] = 6'd10; exp_addr[1] = 6'd20; exp_addr[2] = 6'd10; exp_addr[3] = 6'd20;
      do_reset();
      set_a(1'b1, 1'b0, 6'd10, 8'h00);
      set_b(1'b1, 1'b0, 6'd20, 8'h00);
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if ({bus.a_gnt, bus.b_gnt} !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {bus.a_gnt, bus.b_gnt}, exp_gnt[i]); end
         checks++; if (bus.ram_addr !== exp_addr[i]) begin errors++; $display("FAIL rr_addr[%0d]: got %0d want %0d", i, bus.ram_addr, exp_addr[i]); end
         if (i > 0) begin
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== exp_gnt[i-1]) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {bus.a_rvalid, bus.b_rvalid}, exp_gnt[i-1]); end
         end
         tick();
      end
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      tick();
   endtask

   task automatic test_cross_write_read();
      // last grant went to B, so B writing then A reading exercises both sides
      set_b(1'b1, 1'b1, 6'd25, 8'h55);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin errors++; $display("FAIL xw_gnt: got %b want 01", {bus.a_gnt, bus.b_gnt}); end
      tick();
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      set_a(1'b1, 1'b0, 6'd25, 8'h00);
      #1;
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL xr_gnt: got %b want 1", bus.a_gnt); end
      tick();
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      checks++; if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 8'h55}) begin errors++; $display("FAIL xr_data: got v=%b d=%h want v=1 d=55", bus.a_rvalid, bus.a_rdata); end
      tick();
      #1;
      checks++; if (bus.a_rvalid !== 1'b0) begin errors++; $display("FAIL xr_one_cycle: got %b want 0", bus.a_rvalid); end
   endtask

   task automatic test_contended_reads();
      set_b(1'b1, 1'b1, 6'd55, 8'h45);
      tick();
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      do_reset();
      set_a(1'b1, 1'b0, 6'd5, 8'h00);
      set_b(1'b1, 1'b0, 6'd55, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin errors++; $display("FAIL cr_gnt0: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
      tick();
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin errors++; $display("FAIL cr_gnt1: got %b want 01", {bus.a_gnt, bus.b_gnt}); end
      checks++; if ({bus.a_rvalid, bus.b_rvalid, bus.a_rdata} !== {2'b10, 8'hAA}) begin errors++; $display("FAIL cr_a_ret: got av=%b bv=%b d=%h want av=1 bv=0 d=aa", bus.a_rvalid, bus.b_rvalid, bus.a_rdata); end
      tick();
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      checks++; if ({bus.a_rvalid, bus.b_rvalid, bus.b_rdata} !== {2'b01, 8'h45}) begin errors++; $display("FAIL cr_b_ret: got av=%b bv=%b d=%h want av=0 bv=1 d=45", bus.a_rvalid, bus.b_rvalid, bus.b_rdata); end
      tick();
      #1;
      checks++; if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin errors++; $display("FAIL cr_idle: got %b want 00", {bus.a_rvalid, bus.b_rvalid}); end
   endtask

   task automatic test_reset_mid_op();
      rst = 1'b1;
      set_a(1'b1, 1'b1, 6'd55, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.ram_we} !== 2'b00) begin errors++; $display("FAIL rm_no_write: got gnt=%b we=%b want 0 0", bus.a_gnt, bus.ram_we); end
      tick();
      rst = 1'b0;
      set_a(1'b1, 1'b0, 6'd55, 8'h00);
      #1;
      checks++; if (bus.a_gnt !== 1'b1) begin errors++; $display("FAIL rm_rd_gnt: got %b want 1", bus.a_gnt); end
      tick();
      set_a(1'b1, 1'b0, 6'd5, 8'h00);
      #1;
      checks++; if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 8'h45}) begin errors++; $display("FAIL rm_kept: got v=%b d=%h want v=1 d=45", bus.a_rvalid, bus.a_rdata); end
      tick();
      rst = 1'b1;
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin errors++; $display("FAIL rm_drop: got %b want 00", {bus.a_rvalid, bus.b_rvalid}); end
      // last_gnt back to B after reset, so a tie goes to A
      set_a(1'b1, 1'b0, 6'd1, 8'h00);
      set_b(1'b1, 1'b0, 6'd2, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin errors++; $display("FAIL rm_tie: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
      tick();
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      tick();
   endtask

   task automatic test_back_to_back();
      // last grant was A; B streams three reads alone, then A joins
      set_b(1'b1, 1'b0, 6'd55, 8'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin errors++; $display("FAIL bb_b_gnt[%0d]: got %b want 01", i, {bus.a_gnt, bus.b_gnt}); end
         if (i > 0) begin
            checks++; if ({bus.b_rvalid, bus.b_rdata} !== {1'b1, 8'h45}) begin errors++; $display("FAIL bb_b_rvalid[%0d]: got v=%b d=%h want v=1 d=45", i, bus.b_rvalid, bus.b_rdata); end
         end
         tick();
      end
      set_a(1'b1, 1'b0, 6'd5, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin errors++; $display("FAIL bb_a_join: got %b want 10", {bus.a_gnt, bus.b_gnt}); end
      checks++; if (bus.b_rvalid !== 1'b1) begin errors++; $display("FAIL bb_b_last_rvalid: got %b want 1", bus.b_rvalid); end
      tick();
      set_a(1'b0, 1'b0, 6'd0, 8'h00);
      #1;
      checks++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin errors++; $display("FAIL bb_b_after: got %b want 01", {bus.a_gnt, bus.b_gnt}); end
      checks++; if ({bus.a_rvalid, bus.a_rdata} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL bb_a_data: got v=%b d=%h want v=1 d=aa", bus.a_rvalid, bus.a_rdata); end
      tick();
      set_b(1'b0, 1'b0, 6'd0, 8'h00);
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_cross_write_read();
      test_contended_reads();
      test_reset_mid_op();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
